// File: rtl/tristate_pkg.sv
// Shared encodings and small helpers for the tristate register file.
package tristate_pkg;

  typedef enum logic [1:0] {
    OP_MOVE  = 2'b00,
    OP_READ  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TURN = 2'b01,
    S_EXEC = 2'b10
  } state_e;

  // EXT: an outside agent owned the bus last; INT: this block drove it last.
  typedef enum logic {
    DIR_EXT = 1'b0,
    DIR_INT = 1'b1
  } dir_e;

  // Operations that put a register value onto the shared bus.
  function automatic logic drives_bus(input op_e op);
    return (op == OP_READ) || (op == OP_MOVE);
  endfunction

  // A turnaround is needed only when the op uses the bus in the opposite
  // direction from the previous owner; CLEAR never touches the bus.
  function automatic logic needs_turn(input op_e op, input dir_e last);
    logic result;
    result = 1'b0;
    case (op)
      OP_READ, OP_MOVE: result = (last != DIR_INT);
      OP_LOAD:          result = (last != DIR_EXT);
      default:          result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tristate_buf.sv
// Tristate driver: the single point where the shared bus is released to Z.
module tristate_buf #(
  parameter int WIDTH = 8
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] d,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = oe ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/tristate_regfile.sv
// Register file on a shared bidirectional bus with a turnaround sequencer
// that leaves the bus undriven whenever ownership changes direction.
module tristate_regfile
  import tristate_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int TURNAROUND = 1
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [WIDTH-1:0] data,
  input  logic [1:0]    op,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] wr_addr,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          bus_oe
);

  localparam logic [2:0] TURN_INIT = 3'(TURNAROUND - 1);

  state_e           state;
  op_e              op_in;
  op_e              op_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  dir_e             last_dir;
  logic [2:0]       turn_cnt;
  logic [WIDTH-1:0] drive_q;
  logic [WIDTH-1:0] regs [DEPTH];

  assign op_in = op_e'(op);

  // Source lookup; addresses beyond DEPTH read as zero.
  function automatic logic [WIDTH-1:0] read_src(input logic [AW-1:0] a);
    logic [WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == AW'(i)) result = regs[i];
    end
    return result;
  endfunction

  // Sequencer: accept in IDLE, optional turnaround, one EXEC cycle, done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_q     <= OP_MOVE;
      rd_q     <= '0;
      wr_q     <= '0;
      last_dir <= DIR_EXT;
      turn_cnt <= '0;
      drive_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bus_oe   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_in;
            rd_q <= rd_addr;
            wr_q <= wr_addr;
            busy <= 1'b1;
            if (needs_turn(op_in, last_dir)) begin
              state    <= S_TURN;
              turn_cnt <= TURN_INIT;
            end else begin
              state   <= S_EXEC;
              bus_oe  <= drives_bus(op_in);
              drive_q <= read_src(rd_addr);
            end
          end
        end
        S_TURN: begin
          if (turn_cnt == 3'd0) begin
            state   <= S_EXEC;
            bus_oe  <= drives_bus(op_q);
            drive_q <= read_src(rd_q);
          end else begin
            turn_cnt <= turn_cnt - 3'd1;
          end
        end
        S_EXEC: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          bus_oe <= 1'b0;
          if (drives_bus(op_q)) begin
            last_dir <= DIR_INT;
          end else if (op_q == OP_LOAD) begin
            last_dir <= DIR_EXT;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

  // Register writes at the closing edge of EXEC; MOVE and LOAD capture the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == S_EXEC) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_q == AW'(i)) begin
          case (op_q)
            OP_MOVE, OP_LOAD: regs[i] <= data;
            OP_CLEAR:         regs[i] <= '0;
            default:          regs[i] <= regs[i];
          endcase
        end
      end
    end
  end

  tristate_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .oe (bus_oe),
    .d  (drive_q),
    .bus(data)
  );

endmodule

// File: tb/tb_tristate_regfile.sv
// Directed bench: a DEPTH=4 and a DEPTH=3 register file run in lockstep
// from shared control so out-of-range behaviour can be compared directly.
module tb_tristate_regfile;

  localparam logic [1:0] MOVE  = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [1:0] rd_addr;
  logic [1:0] wr_addr;
  logic       tb_oe;
  logic [7:0] tb_drive;
  wire  [7:0] data4;
  wire  [7:0] data3;
  logic       busy4, done4, oe4;
  logic       busy3, done3, oe3;
  int         checks;
  int         errors;

  assign data4 = tb_oe ? tb_drive : 8'hzz;
  assign data3 = tb_oe ? tb_drive : 8'hzz;

  tristate_regfile #(.WIDTH(8), .DEPTH(4), .AW(2), .TURNAROUND(1)) dut4 (
    .clk(clk), .rst(rst), .data(data4), .op(op), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .start(start), .busy(busy4), .done(done4), .bus_oe(oe4)
  );

  tristate_regfile #(.WIDTH(8), .DEPTH(3), .AW(2), .TURNAROUND(1)) dut3 (
    .clk(clk), .rst(rst), .data(data3), .op(op), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .start(start), .busy(busy3), .done(done3), .bus_oe(oe3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic b, input logic d, input logic oe);
    check({tag, "_busy4"}, {7'b0, busy4}, {7'b0, b});
    check({tag, "_done4"}, {7'b0, done4}, {7'b0, d});
    check({tag, "_oe4"},   {7'b0, oe4},   {7'b0, oe});
    check({tag, "_busy3"}, {7'b0, busy3}, {7'b0, b});
    check({tag, "_done3"}, {7'b0, done3}, {7'b0, d});
    check({tag, "_oe3"},   {7'b0, oe3},   {7'b0, oe});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic [1:0] r, input logic [1:0] w);
    op      = o;
    rd_addr = r;
    wr_addr = w;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 8 && !done4; n++) step();
    check({tag, "_done4"}, {7'b0, done4}, 8'h01);
    check({tag, "_done3"}, {7'b0, done3}, 8'h01);
  endtask

  task automatic check_output(input string tag, input logic [1:0] a,
                              input logic [7:0] exp4, input logic [7:0] exp3);
    apply_stimulus(READ, a, 2'd0);
    for (int n = 0; n < 8 && !oe4; n++) step();
    check({tag, "_oe4"},   {7'b0, oe4}, 8'h01);
    check({tag, "_oe3"},   {7'b0, oe3}, 8'h01);
    check({tag, "_data4"}, data4, exp4);
    check({tag, "_data3"}, data3, exp3);
    step();
    check({tag, "_done4"}, {7'b0, done4}, 8'h01);
    check({tag, "_done3"}, {7'b0, done3}, 8'h01);
  endtask

  // Linear directed sequence.
  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    op       = MOVE;
    rd_addr  = 2'd0;
    wr_addr  = 2'd0;
    tb_oe    = 1'b0;
    tb_drive = 8'h00;

    #1 rst = 1'b0;
    #1 status("por", 1'b0, 1'b0, 1'b0);
    #10 rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) check_output("rst_read", 2'(i), 8'h00, 8'h00);

    // Mid-simulation reset lands in a done cycle and must clear it at once.
    rst = 1'b0;
    #1 status("mid_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // LOAD with no turnaround: EXEC next cycle, done one cycle later.
    tb_drive = 8'hA5;
    tb_oe    = 1'b1;
    apply_stimulus(LOAD, 2'd0, 2'd2);
    status("load_exec", 1'b1, 1'b0, 1'b0);
    step();
    status("load_done", 1'b0, 1'b1, 1'b0);
    tb_oe = 1'b0;

    // READ after LOAD: one turnaround cycle, then the block drives.
    apply_stimulus(READ, 2'd2, 2'd0);
    status("read_turn", 1'b1, 1'b0, 1'b0);
    step();
    status("read_exec", 1'b1, 1'b0, 1'b1);
    check("read_data4", data4, 8'hA5);
    check("read_data3", data3, 8'hA5);
    step();
    status("read_done", 1'b0, 1'b1, 1'b0);

    // MOVE reg2 -> reg1, then READ reg1 on the done cycle, no turnaround.
    apply_stimulus(MOVE, 2'd2, 2'd1);
    status("move_exec", 1'b1, 1'b0, 1'b1);
    check("move_data4", data4, 8'hA5);
    step();
    status("move_done", 1'b0, 1'b1, 1'b0);
    apply_stimulus(READ, 2'd1, 2'd0);
    status("mvrd_exec", 1'b1, 1'b0, 1'b1);
    check("mvrd_data4", data4, 8'hA5);
    check("mvrd_data3", data3, 8'hA5);
    step();
    status("mvrd_done", 1'b0, 1'b1, 1'b0);

    // LOAD reg0 with a start pulse during TURN that must be ignored.
    tb_drive = 8'h3C;
    tb_oe    = 1'b1;
    apply_stimulus(LOAD, 2'd0, 2'd0);
    status("ign_turn", 1'b1, 1'b0, 1'b0);
    apply_stimulus(READ, 2'd2, 2'd0);
    status("ign_exec", 1'b1, 1'b0, 1'b0);
    step();
    status("ign_done", 1'b0, 1'b1, 1'b0);
    tb_oe = 1'b0;
    step();
    status("ign_idle", 1'b0, 1'b0, 1'b0);

    // CLEAR reg1 needs no bus and no turnaround.
    apply_stimulus(CLEAR, 2'd0, 2'd1);
    status("clr_exec", 1'b1, 1'b0, 1'b0);
    step();
    status("clr_done", 1'b0, 1'b1, 1'b0);
    check_output("clr_read1", 2'd1, 8'h00, 8'h00);
    check_output("read0", 2'd0, 8'h3C, 8'h3C);

    // Address 3 is valid for DEPTH=4 but out of range for DEPTH=3.
    tb_drive = 8'h77;
    tb_oe    = 1'b1;
    apply_stimulus(LOAD, 2'd0, 2'd3);
    wait_done("oor_load");
    tb_oe = 1'b0;
    check_output("oor_read3", 2'd3, 8'h77, 8'h00);
    check_output("oor_read0", 2'd0, 8'h3C, 8'h3C);
    check_output("oor_read2", 2'd2, 8'hA5, 8'hA5);
    check_output("oor_read1", 2'd1, 8'h00, 8'h00);

    // Reset asserted during a READ EXEC cycle releases the bus immediately.
    apply_stimulus(READ, 2'd0, 2'd0);
    status("pre_rst", 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 status("in_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    status("post_rst", 1'b0, 1'b0, 1'b0);
    check_output("post_read0", 2'd0, 8'h00, 8'h00);
    check_output("post_read2", 2'd2, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
